// File: rtl/snoop_responder_if.sv
// Snoop bus bundle between the bus controller and one cache-side responder.
// The controller drives search/inv_from_other/BOCI; the responder answers
// with search_found, block_state and the forwarded block data.
interface snoop_responder_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 64
);
  logic              search;
  logic              inv_from_other;
  logic [ADDR_W-1:0] BOCI;
  logic              search_found;
  logic [1:0]        block_state;
  logic [DATA_W-1:0] snp_data;

  modport master (
    output search, inv_from_other, BOCI,
    input  search_found, block_state, snp_data
  );

  modport slave (
    input  search, inv_from_other, BOCI,
    output search_found, block_state, snp_data
  );
endinterface

// File: rtl/snoop_responder.sv
// Cache-side MSI snoop responder (one per CPU d-cache).
// Looks up BOCI in the local tag/state/data array, answers search requests,
// applies invalidations and M->S downgrades, and stalls the local CPU port
// while snoop work is in flight.
// Optional feature macro: WRITEBACK_ON_INV_EN -- when defined, invalidating
// an M block first writes it back through the wb_* handshake.
// The interface instance must use the same ADDR_W/DATA_W as this module.
module snoop_responder #(
  parameter int ADDR_W      = 13,
  parameter int IDX_W       = 6,
  parameter int OFF_W       = 2,
  parameter int DATA_W      = 64,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  snoop_responder_if.slave               bus,
  output logic                           arr_rd,
  output logic [IDX_W-1:0]               arr_idx,
  input  logic [ADDR_W-IDX_W-OFF_W-1:0]  arr_tag_rd,
  input  logic [1:0]                     arr_state_rd,
  input  logic [DATA_W-1:0]              arr_data_rd,
  output logic                           arr_we,
  output logic [1:0]                     arr_state_wr,
  output logic                           wb_req,
  output logic [ADDR_W-1:0]              wb_addr,
  output logic [DATA_W-1:0]              wb_data,
  input  logic                           wb_ack,
  output logic                           snp_busy
);

  localparam int BLK_W = ADDR_W - OFF_W;
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_M = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    RESPOND,
    INV_LOOKUP,
    UPDATE,
    WB
  } state_t;

  state_t              state_reg, state_next;
  logic [BLK_W-1:0]    blk_reg, blk_next;     // latched block address (tag+idx)
  logic [1:0]          st_reg, st_next;       // state of the matched block
  logic [DATA_W-1:0]   data_reg, data_next;   // data of the matched block
  logic                inv_pend_reg, inv_pend_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;

  logic [IDX_W-1:0]    boci_idx;
  logic [BLK_W-1:0]    boci_blk;
  logic [TAG_W-1:0]    blk_tag;
  logic [IDX_W-1:0]    blk_idx;
  logic                hit;
  logic                req_ok;
  logic [OFF_W-1:0]    unused_off;

  assign boci_idx   = bus.BOCI[IDX_W+OFF_W-1:OFF_W];
  assign boci_blk   = bus.BOCI[ADDR_W-1:OFF_W];
  assign unused_off = bus.BOCI[OFF_W-1:0];
  assign blk_tag    = blk_reg[BLK_W-1:IDX_W];
  assign blk_idx    = blk_reg[IDX_W-1:0];
  assign hit        = (arr_tag_rd == blk_tag) && (arr_state_rd != ST_I);
  // New requests are not accepted while reset is held, so every output is 0.
  assign req_ok     = rst_n;

  assign snp_busy = (state_reg != IDLE) | (req_ok & (bus.search | bus.inv_from_other));

`ifndef WRITEBACK_ON_INV_EN
  logic unused_wb_ack;
  assign unused_wb_ack = wb_ack;
`endif

  // State and captured lookup results; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      blk_reg      <= '0;
      st_reg       <= ST_I;
      data_reg     <= '0;
      inv_pend_reg <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      blk_reg      <= blk_next;
      st_reg       <= st_next;
      data_reg     <= data_next;
      inv_pend_reg <= inv_pend_next;
      cnt_reg      <= cnt_next;
    end
  end

  // Next-state and output decode for the snoop sequencer.
  always_comb begin
    state_next       = state_reg;
    blk_next         = blk_reg;
    st_next          = st_reg;
    data_next        = data_reg;
    inv_pend_next    = inv_pend_reg;
    cnt_next         = cnt_reg;
    bus.search_found = 1'b0;
    bus.block_state  = ST_I;
    bus.snp_data     = '0;
    arr_rd           = 1'b0;
    arr_idx          = '0;
    arr_we           = 1'b0;
    arr_state_wr     = ST_I;
    wb_req           = 1'b0;
    wb_addr          = '0;
    wb_data          = '0;

    case (state_reg)
      IDLE: begin
        // A search wins over a simultaneous invalidate; the invalidate is
        // remembered and applied after the response.
        if (req_ok && bus.search) begin
          arr_rd        = 1'b1;
          arr_idx       = boci_idx;
          blk_next      = boci_blk;
          inv_pend_next = bus.inv_from_other;
          state_next    = LOOKUP;
        end else if (req_ok && bus.inv_from_other) begin
          arr_rd     = 1'b1;
          arr_idx    = boci_idx;
          blk_next   = boci_blk;
          state_next = INV_LOOKUP;
        end
      end

      LOOKUP: begin
        bus.search_found = hit;
        bus.block_state  = hit ? arr_state_rd : ST_I;
        bus.snp_data     = arr_data_rd;
        if (hit) begin
          st_next       = arr_state_rd;
          data_next     = arr_data_rd;
          cnt_next      = CNT_W'(HOLD_CYCLES);
          inv_pend_next = inv_pend_reg | bus.inv_from_other;
          state_next    = RESPOND;
        end else begin
          inv_pend_next = 1'b0;
          state_next    = IDLE;
        end
      end

      RESPOND: begin
        bus.search_found = 1'b1;
        bus.block_state  = st_reg;
        bus.snp_data     = data_reg;
        inv_pend_next    = inv_pend_reg | bus.inv_from_other;
        cnt_next         = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          // A clean S hit with nothing pending needs no array write.
          if (inv_pend_reg || bus.inv_from_other || (st_reg == ST_M))
            state_next = UPDATE;
          else
            state_next = IDLE;
        end
      end

      INV_LOOKUP: begin
        if (hit) begin
          st_next       = arr_state_rd;
          data_next     = arr_data_rd;
          inv_pend_next = 1'b1;
          state_next    = UPDATE;
        end else begin
          state_next = IDLE;
        end
      end

      UPDATE: begin
        arr_idx       = blk_idx;
        inv_pend_next = 1'b0;
        state_next    = IDLE;
        if (inv_pend_reg) begin
          arr_we       = 1'b1;
          arr_state_wr = ST_I;
`ifdef WRITEBACK_ON_INV_EN
          if (st_reg == ST_M)
            state_next = WB;
`endif
        end else if (st_reg == ST_M) begin
          // Owner forwarded its dirty copy; both caches now share it.
          arr_we       = 1'b1;
          arr_state_wr = ST_S;
        end
      end

      WB: begin
`ifdef WRITEBACK_ON_INV_EN
        wb_req  = 1'b1;
        wb_addr = {blk_reg, {OFF_W{1'b0}}};
        wb_data = data_reg;
        if (wb_ack)
          state_next = IDLE;
`else
        state_next = IDLE;
`endif
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/snoop_responder.md
Name: snoop_responder

Overview:
- Cache-side responder for the dual-CPU MSI snoop protocol; one instance per CPU d-cache.
- Answers the bus controller's search requests (search + BOCI) with search_found, block_state and forwarded block data.
- Applies inv_from_other invalidations and M->S downgrades to the local tag/state array.
- Stalls the local CPU's cache port while snoop work is in progress.

Parameters:
- ADDR_W, 13, full block address width (matches BOCI)
- IDX_W, 6, direct-mapped set index width
- OFF_W, 2, block offset width; TAG_W = ADDR_W-IDX_W-OFF_W
- DATA_W, 64, block data width forwarded to the other CPU
- HOLD_CYCLES, 2, extra cycles search_found/data are held after the lookup cycle (min 1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- search  in  1  bus request to search this cache for BOCI
- inv_from_other  in  1  bus request to invalidate the block at BOCI
- BOCI  in  ADDR_W  bus-out/cache-in address
- search_found  out  1  valid block matching BOCI present
- block_state  out  2  state of the matched block (00 I, 01 S, 10 M)
- snp_data  out  DATA_W  forwarded block data
- snp_busy  out  1  stall to local CPU cache port
- arr_rd  out  1  tag/state/data array read strobe (1-cycle latency)
- arr_idx  out  IDX_W  array index, read and write
- arr_tag_rd  in  TAG_W  tag read data
- arr_state_rd  in  2  state read data
- arr_data_rd  in  DATA_W  block read data
- arr_we  out  1  state write strobe
- arr_state_wr  out  2  state write data
- wb_req  out  1  writeback request (feature only; tie 0 otherwise)
- wb_addr  out  ADDR_W  writeback address
- wb_data  out  DATA_W  writeback data
- wb_ack  in  1  writeback accepted

Behaviour:
- Reset: state IDLE; all outputs 0; block_state=00; inv_pend=0; hold counter=0. Reset mid-operation aborts; no array write issued.
- States: IDLE, LOOKUP, RESPOND, INV_LOOKUP, UPDATE, WB (feature).
- IDLE:
  - search=1: arr_rd=1, arr_idx=BOCI[IDX_W+OFF_W-1:OFF_W] combinationally; latch BOCI into addr_q; go to LOOKUP.
  - Else inv_from_other=1: same read and latch; go to INV_LOOKUP.
  - search and inv_from_other together: search wins; set inv_pend.
- LOOKUP (cycle t+1 after search):
  - hit = (arr_tag_rd==addr_q tag) && arr_state_rd!=00.
  - search_found=hit; block_state = hit ? arr_state_rd : 00; snp_data = arr_data_rd. All combinational this cycle, then registered into st_q/data_q.
  - hit: go to RESPOND with cnt=HOLD_CYCLES.
  - miss: go to IDLE; clear inv_pend.
- RESPOND: drive search_found=1, block_state=st_q, snp_data=data_q from registers; decrement cnt. At cnt==1, go to UPDATE.
- inv_from_other during LOOKUP (hit) or RESPOND sets inv_pend and applies to addr_q; BOCI is ignored after latching.
- UPDATE: arr_we=1, arr_idx from addr_q.
  - inv_pend: arr_state_wr=00. If the WRITEBACK_ON_INV_EN feature is enabled and st_q==M, go to WB; otherwise go to IDLE.
  - Else if st_q==M: arr_state_wr=01 (downgrade after forwarding).
  - Else (S, no inv): no write, arr_we=0.
  - Clear inv_pend; go to IDLE.
- INV_LOOKUP: hit as in LOOKUP, with search_found=0.
  - hit: capture st_q/data_q; inv_pend=1; go to UPDATE.
  - miss: go to IDLE.
- snp_busy = (state!=IDLE) | search | inv_from_other.
- search arriving while not IDLE is ignored. The bus never issues one, so this is a protocol error with no recovery.

Optional Feature:
- Macro: WRITEBACK_ON_INV_EN.
- Defined: invalidating an M block enters WB. wb_req=1 with wb_addr={addr_q tag,idx,OFF_W'b0} and wb_data=data_q, held stable until the cycle wb_ack=1. Then go to IDLE with snp_busy still asserted during WB. A wb_ack seen in the same cycle as the wb_req rise completes in 1 cycle.
- Undefined: the M block is dropped straight to I. wb_req, wb_addr and wb_data are tied 0; wb_ack is unused.

Test Plan:
- Array idx 5 tag 0x1B state S; search=1, BOCI={0x1B,6'd5,2'b0} -> arr_rd at t0; search_found=1, block_state=01 at t1..t3; no arr_we; IDLE at t4.
- Same address with state M, data 0xDEAD_BEEF -> snp_data=0xDEAD_BEEF at t1..t3; arr_we=1, arr_state_wr=01 at t4.
- Search to idx 5 with tag 0x1C (mismatch) -> search_found=0, block_state=00 at t1; IDLE at t2; snp_busy high t0..t1 only.
- State S hit, then inv_from_other=1 at t2 -> arr_we=1, arr_state_wr=00 at t4; inv_pend cleared.
- inv_from_other alone on an M block, feature on, wb_ack delayed 3 cycles -> arr_state_wr=00 at t2; wb_req t3..t5; IDLE at t6. Feature off -> IDLE at t3.
- rst_n low during RESPOND -> all outputs 0 immediately; no arr_we after release.
